cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/alu_ctrl_decode.sv | 45 ++++
 rtl/cpu_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants and types for the multi-cycle CPU controller.
//   - opcode and R-type funct encodings of the 16-bit ISA
//   - ALU_CTRL operation codes understood by the datapath ALU
//   - state_t: controller sequencing states
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h8;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd2;
  localparam logic [2:0] FN_SLT = 3'd7;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction decode for the ALU.
//   opcode      in  4 : instruction opcode field
//   funct       in  3 : R-type funct field
//   alu_ctrl    out 4 : ALU operation code (ALU_NOP when illegal)
//   alu_src_imm out 1 : second ALU operand is sign-extended imm6
//   illegal     out 1 : opcode/funct combination is not decodable
// Build option: CPU_CTRL_SLT_EN makes funct 7 decode as slt; without it
// funct 7 is treated as illegal.
module alu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_imm,
  output logic       illegal
);

  always_comb begin
    alu_ctrl    = ALU_NOP;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: alu_ctrl = ALU_ADD;
          FN_SUB: alu_ctrl = ALU_SUB;
`ifdef CPU_CTRL_SLT_EN
          FN_SLT: alu_ctrl = ALU_SLT;
`endif
          default: illegal = 1'b1;
        endcase
      end
      // addi, lw and sw all compute rs + imm6
      OP_ADDI, OP_LW, OP_SW: begin
        alu_ctrl    = ALU_ADD;
        alu_src_imm = 1'b1;
      end
      // beq compares by subtraction; the datapath reports alu_zero
      OP_BEQ:  alu_ctrl = ALU_SUB;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for the 16-bit CPU.
// Sequences one instruction at a time through FETCH, DECODE, EXEC, MEM, WB.
//   clk, rst_n            : clock, asynchronous active-low reset
//   instr_valid, instr    : fetch port instruction offer
//   instr_ready           : controller accepts an instruction (FETCH only)
//   alu_zero              : ALU result is zero (sampled in EXEC of beq)
//   mem_ready             : data memory access complete (sampled in MEM)
//   ALU_CTRL, alu_src_imm : ALU operation and operand-2 select
//   rs_addr, rt_addr      : register-file read addresses
//   wr_addr, reg_write    : register-file write address and strobe
//   wb_sel_mem            : write-back data from memory (1) or ALU (0)
//   mem_read, mem_write   : data-memory strobes, held until mem_ready
//   pc_inc, pc_branch     : PC update pulses
//   illegal               : pulse during DECODE of an undecodable instruction
//   dbg_state             : current state_t encoding
// Build option: CPU_CTRL_SLT_EN enables the slt R-type instruction.
//
// Handshake: an instruction transfers on a rising edge where instr_valid
// and instr_ready are both 1. instr_ready is high only in FETCH, and FETCH
// is left on the transfer edge, so at most one instruction is taken per
// FETCH visit. instr_valid is not required to stay high while ready is low.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  ALU_CTRL,
  output logic        alu_src_imm,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  wr_addr,
  output logic        reg_write,
  output logic        wb_sel_mem,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        illegal,
  output logic [2:0]  dbg_state
);

  state_t      state, state_nx;
  logic [15:0] ir, ir_nx;
  logic [3:0]  op_nx;
  logic [3:0]  dec_alu;
  logic        dec_imm;
  logic        dec_ill;

  assign op_nx     = ir_nx[15:12];
  assign dbg_state = state;

  // Decode is taken on the value IR will hold after the edge, so every
  // output can be registered together with the state and still reflect
  // exactly (state, IR) during the following cycle.
  alu_ctrl_decode u_dec (
    .opcode      (ir_nx[15:12]),
    .funct       (ir_nx[2:0]),
    .alu_ctrl    (dec_alu),
    .alu_src_imm (dec_imm),
    .illegal     (dec_ill)
  );

  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        // instr_ready is 1 whenever state is FETCH
        if (instr_valid) begin
          ir_nx    = instr;
          state_nx = DECODE;
        end
      end
      DECODE: state_nx = dec_ill ? FETCH : EXEC;
      EXEC: begin
        case (op_nx)
          OP_LW, OP_SW: state_nx = MEM;
          OP_BEQ:       state_nx = FETCH;
          default:      state_nx = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) state_nx = (op_nx == OP_LW) ? WB : FETCH;
      end
      WB:      state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      instr_ready <= 1'b0;
      ALU_CTRL    <= ALU_NOP;
      alu_src_imm <= 1'b0;
      rs_addr     <= '0;
      rt_addr     <= '0;
      wr_addr     <= '0;
      reg_write   <= 1'b0;
      wb_sel_mem  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      pc_inc      <= 1'b0;
      pc_branch   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_nx;
      ir          <= ir_nx;
      instr_ready <= (state_nx == FETCH);
      pc_inc      <= (state == FETCH) && instr_valid;
      illegal     <= (state_nx == DECODE) && dec_ill;
      // Read addresses stay on the register file from DECODE through MEM
      // so the ALU operands (and sw store data) remain valid.
      if (state_nx == DECODE || state_nx == EXEC || state_nx == MEM) begin
        rs_addr <= ir_nx[11:9];
        rt_addr <= ir_nx[8:6];
      end else begin
        rs_addr <= '0;
        rt_addr <= '0;
      end
      if (state_nx == EXEC) begin
        ALU_CTRL    <= dec_alu;
        alu_src_imm <= dec_imm;
      end else if (state_nx == MEM) begin
        ALU_CTRL    <= ALU_ADD;
        alu_src_imm <= 1'b1;
      end else begin
        ALU_CTRL    <= ALU_NOP;
        alu_src_imm <= 1'b0;
      end
      mem_read   <= (state_nx == MEM) && (op_nx == OP_LW);
      mem_write  <= (state_nx == MEM) && (op_nx == OP_SW);
      reg_write  <= (state_nx == WB);
      wb_sel_mem <= (state_nx == WB) && (op_nx == OP_LW);
      if (state_nx == WB) wr_addr <= (op_nx == OP_RTYPE) ? ir_nx[5:3] : ir_nx[8:6];
      else                wr_addr <= '0;
      // Branch decision is taken on the EXEC->FETCH edge; the pulse is
      // visible during the first FETCH cycle that follows.
      pc_branch <= (state == EXEC) && (op_nx == OP_BEQ) && alu_zero;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed self-checking bench for cpu_ctrl_fsm.
// Build option: CPU_CTRL_SLT_EN selects which slt behaviour is expected.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        alu_zero;
  logic        mem_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm;
  logic [2:0]  rs_addr, rt_addr, wr_addr;
  logic        reg_write, wb_sel_mem, mem_read, mem_write;
  logic        pc_inc, pc_branch, illegal;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected write-back register addresses, in issue order
  logic [2:0] exp_q[$];

  cpu_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .ALU_CTRL    (alu_ctrl),
    .alu_src_imm (alu_src_imm),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_addr     (wr_addr),
    .reg_write   (reg_write),
    .wb_sel_mem  (wb_sel_mem),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, instr_ready, alu_ctrl, alu_src_imm, rs_addr, rt_addr, wr_addr,
            reg_write, wb_sel_mem, mem_read, mem_write, pc_inc, pc_branch, illegal};
  endfunction

  // Scoreboard: every register write must match the next expected address
  always @(negedge clk) begin
    if (rst_n && reg_write) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
      else                   check("wb_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] word);
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      step();
      waited++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("pc_inc", 32'(pc_inc), 32'd1);
    check("ready_low_decode", 32'(instr_ready), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    step();
    step();
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    check("ready_after_reset", 32'(instr_ready), 32'd1);
    check("fetch_state", 32'(dbg_state), 32'(FETCH));

    // add r1,r2 -> r3
    exp_q.push_back(3'd3);
    accept(16'h0298);
    check("add_rs", 32'(rs_addr), 32'd1);
    check("add_rt", 32'(rt_addr), 32'd2);
    check("add_alu_decode", 32'(alu_ctrl), 32'd0);
    check("add_illegal", 32'(illegal), 32'd0);
    step();
    check("add_alu_exec", 32'(alu_ctrl), 32'd2);
    check("add_src", 32'(alu_src_imm), 32'd0);
    check("add_pc_inc_once", 32'(pc_inc), 32'd0);
    step();
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_wr_addr", 32'(wr_addr), 32'd3);
    check("add_wb_sel", 32'(wb_sel_mem), 32'd0);
    step();
    check("add_back_fetch", 32'(instr_ready), 32'd1);
    check("add_wr_done", 32'(reg_write), 32'd0);

    // sub r5,r6 -> r7
    exp_q.push_back(3'd7);
    accept(16'h0BBA);
    step();
    check("sub_alu_exec", 32'(alu_ctrl), 32'd6);
    step();
    step();
    check("sub_back_fetch", 32'(instr_ready), 32'd1);

    // addi r6 = r4 + 2
    exp_q.push_back(3'd6);
    accept(16'h1982);
    step();
    check("addi_alu", 32'(alu_ctrl), 32'd2);
    check("addi_src", 32'(alu_src_imm), 32'd1);
    step();
    check("addi_wr_addr", 32'(wr_addr), 32'd6);
    step();
    check("addi_back_fetch", 32'(instr_ready), 32'd1);

    // beq taken
    accept(16'h8285);
    step();
    check("beq_alu", 32'(alu_ctrl), 32'd6);
    check("beq_src", 32'(alu_src_imm), 32'd0);
    alu_zero = 1'b1;
    step();
    alu_zero = 1'b0;
    check("beq_taken_branch", 32'(pc_branch), 32'd1);
    check("beq_taken_fetch", 32'(instr_ready), 32'd1);
    step();
    check("beq_branch_pulse", 32'(pc_branch), 32'd0);

    // beq not taken
    accept(16'h8285);
    step();
    alu_zero = 1'b0;
    step();
    check("beq_nt_branch", 32'(pc_branch), 32'd0);
    check("beq_nt_fetch", 32'(instr_ready), 32'd1);

    // lw r5 <- [r1+3], memory slow for 3 cycles
    exp_q.push_back(3'd5);
    mem_ready = 1'b0;
    accept(16'h4343);
    step();
    check("lw_exec_alu", 32'(alu_ctrl), 32'd2);
    check("lw_exec_src", 32'(alu_src_imm), 32'd1);
    check("lw_exec_no_read", 32'(mem_read), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("lw_mem_read", 32'(mem_read), 32'd1);
      check("lw_mem_alu", {28'd0, alu_ctrl}, 32'd2);
      check("lw_mem_src", 32'(alu_src_imm), 32'd1);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    check("lw_wb_write", 32'(reg_write), 32'd1);
    check("lw_wb_sel", 32'(wb_sel_mem), 32'd1);
    check("lw_wb_addr", 32'(wr_addr), 32'd5);
    check("lw_read_dropped", 32'(mem_read), 32'd0);
    step();
    check("lw_back_fetch", 32'(instr_ready), 32'd1);

    // sw with memory already ready: 3 cycles
    mem_ready = 1'b1;
    accept(16'h54C1);
    step();
    step();
    check("sw_mem_write", 32'(mem_write), 32'd1);
    step();
    mem_ready = 1'b0;
    check("sw_back_fetch", 32'(instr_ready), 32'd1);
    check("sw_write_done", 32'(mem_write), 32'd0);

    // slt r1,r2 -> r3
`ifdef CPU_CTRL_SLT_EN
    exp_q.push_back(3'd3);
    accept(16'h029F);
    check("slt_not_illegal", 32'(illegal), 32'd0);
    step();
    check("slt_alu", 32'(alu_ctrl), 32'd7);
    step();
    step();
    check("slt_back_fetch", 32'(instr_ready), 32'd1);
`else
    accept(16'h029F);
    check("slt_illegal", 32'(illegal), 32'd1);
    step();
    check("slt_illegal_pulse", 32'(illegal), 32'd0);
    check("slt_back_fetch", 32'(instr_ready), 32'd1);
`endif

    // R-type with undefined funct 1
    accept(16'h0299);
    check("funct1_illegal", 32'(illegal), 32'd1);
    step();
    check("funct1_back_fetch", 32'(instr_ready), 32'd1);

    // opcode 0xF
    accept(16'hF000);
    check("opf_illegal", 32'(illegal), 32'd1);
    check("opf_alu", 32'(alu_ctrl), 32'd0);
    step();
    check("opf_illegal_pulse", 32'(illegal), 32'd0);
    check("opf_back_fetch", 32'(instr_ready), 32'd1);
    check("opf_state", 32'(dbg_state), 32'(FETCH));

    // sw interrupted by reset during MEM
    mem_ready = 1'b0;
    accept(16'h54C1);
    step();
    step();
    check("swr_mem_write", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("swr_async_drop", 32'(mem_write), 32'd0);
    check("swr_all_zero", all_outs(), 32'd0);
    check("swr_state_idle", 32'(dbg_state), 32'(IDLE));
    step();
    rst_n = 1'b1;
    check("swr_ready_low", 32'(instr_ready), 32'd0);
    step();
    check("swr_ready_back", 32'(instr_ready), 32'd1);
    step();
    check("swr_no_write", 32'(mem_write), 32'd0);

    check("wb_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
